// File: rtl/dot_prod_opt.sv
// Signed dot product engine over two host-loadable 27-bit arrays.
// Pipeline stages: read, multiply, accumulate. The engine processes one element per cycle.
module dot_prod_opt #(
    parameter int N    = 1000,
    parameter int AW   = 10,
    parameter int DW   = 27,
    parameter int ACCW = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_enable,
    input  logic            controlArr,
    input  logic [AW-1:0]   init_i_t_a,
    input  logic [ACCW-1:0] init_acc_t_a,
    output logic            w_enable,
    output logic [ACCW-1:0] result,
    input  logic            controlArrWEnable_a,
    input  logic [AW-1:0]   controlArrAddr_a,
    input  logic [DW-1:0]   controlArrWData_a,
    output logic [DW-1:0]   controlArrRData_a,
    input  logic            controlArrWEnable_b,
    input  logic [AW-1:0]   controlArrAddr_b,
    input  logic [DW-1:0]   controlArrWData_b,
    output logic [DW-1:0]   controlArrRData_b
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [AW-1:0]          idx;
    logic [DW-1:0]          mem_a [0:(1<<AW)-1];
    logic [DW-1:0]          mem_b [0:(1<<AW)-1];
    logic [AW-1:0]          addr_a, addr_b;
    logic signed [DW-1:0]   rd_a, rd_b;
    logic                   host_q;
    logic                   issue, issue_last;
    logic                   v1, last1, v2, last2;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc, prod_ext, acc_next;

    // The host owns both address buses while controlArr is high; otherwise the engine index drives them.
    assign addr_a     = controlArr ? controlArrAddr_a : idx;
    assign addr_b     = controlArr ? controlArrAddr_b : idx;
    assign issue      = (state == RUN);
    assign issue_last = issue && (idx == AW'(N - 1));
    assign prod_ext   = {{(ACCW - 2*DW){prod[2*DW-1]}}, prod};
    assign acc_next   = acc + prod_ext;

    always_ff @(posedge clk) begin
        if (controlArr && controlArrWEnable_a) mem_a[controlArrAddr_a] <= controlArrWData_a;
        if (controlArr && controlArrWEnable_b) mem_b[controlArrAddr_b] <= controlArrWData_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a   <= '0;
            rd_b   <= '0;
            host_q <= 1'b0;
        end else begin
            rd_a   <= mem_a[addr_a];
            rd_b   <= mem_b[addr_b];
            host_q <= controlArr;
        end
    end

    assign controlArrRData_a = host_q ? rd_a : '0;
    assign controlArrRData_b = host_q ? rd_b : '0;

    // The valid and last flags travel alongside the data through the read and multiply stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            v2    <= 1'b0;
            last2 <= 1'b0;
            prod  <= '0;
        end else begin
            v1    <= issue;
            last1 <= issue_last;
            v2    <= v1;
            last2 <= last1;
            prod  <= rd_a * rd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            result   <= '0;
            w_enable <= 1'b0;
        end else begin
            w_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (r_enable && !controlArr) begin
                        acc <= init_acc_t_a;
                        if (init_i_t_a >= AW'(N)) begin
                            result   <= init_acc_t_a;
                            w_enable <= 1'b1;
                        end else begin
                            idx   <= init_i_t_a;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    idx <= idx + 1'b1;
                    if (issue_last) state <= DRAIN;
                end
                default: ;
            endcase
            // The accumulator wraps modulo 2**ACCW. The last product goes straight into result.
            if (v2) acc <= acc_next;
            if (v2 && last2) begin
                result   <= acc_next;
                w_enable <= 1'b1;
                state    <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dot_prod_opt.sv
// Randomized self-checking bench for dot_prod_opt. A plain-arithmetic model of the arrays
// provides the expected dot products.
module tb_dot_prod_opt;
    localparam int N = 1000, AW = 10, DW = 27, ACCW = 64;

    logic            clk, rst_n, r_enable, controlArr;
    logic [AW-1:0]   init_i_t_a;
    logic [ACCW-1:0] init_acc_t_a;
    logic            w_enable;
    logic [ACCW-1:0] result;
    logic            controlArrWEnable_a, controlArrWEnable_b;
    logic [AW-1:0]   controlArrAddr_a, controlArrAddr_b;
    logic [DW-1:0]   controlArrWData_a, controlArrWData_b;
    logic [DW-1:0]   controlArrRData_a, controlArrRData_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    int model_a [1024];
    int model_b [1024];
    logic [2*DW-1:0] exp_q [$];

    dot_prod_opt #(.N(N), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
        .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .controlArr(controlArr),
        .init_i_t_a(init_i_t_a), .init_acc_t_a(init_acc_t_a),
        .w_enable(w_enable), .result(result),
        .controlArrWEnable_a(controlArrWEnable_a), .controlArrAddr_a(controlArrAddr_a),
        .controlArrWData_a(controlArrWData_a), .controlArrRData_a(controlArrRData_a),
        .controlArrWEnable_b(controlArrWEnable_b), .controlArrAddr_b(controlArrAddr_b),
        .controlArrWData_b(controlArrWData_b), .controlArrRData_b(controlArrRData_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint model_dot(input int init_i, input longint init_acc);
        longint acc = init_acc;
        for (int i = init_i; i < N; i++) acc += longint'(model_a[i]) * longint'(model_b[i]);
        return acc;
    endfunction

    function automatic int rand_elem();
        return int'($urandom_range(0, 134217727)) - 67108864;
    endfunction

    task automatic write_ab(input int addr, input int da, input int db);
        @(negedge clk);
        controlArr = 1'b1;
        controlArrWEnable_a = 1'b1;
        controlArrWEnable_b = 1'b1;
        controlArrAddr_a = addr[AW-1:0];
        controlArrAddr_b = addr[AW-1:0];
        controlArrWData_a = da[DW-1:0];
        controlArrWData_b = db[DW-1:0];
        model_a[addr] = da;
        model_b[addr] = db;
    endtask

    task automatic host_idle();
        @(negedge clk);
        controlArrWEnable_a = 1'b0;
        controlArrWEnable_b = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 1024; i++) write_ab(i, model_a[i], model_b[i]);
        host_idle();
    endtask

    // Starts a run and waits a bounded number of cycles for the done pulse. The pulse must last one cycle.
    task automatic run_engine(input int init_i, input longint init_acc, output longint got,
                              output int lat, output bit seen);
        @(negedge clk);
        controlArrWEnable_a = 1'b0;
        controlArrWEnable_b = 1'b0;
        controlArr = 1'b0;
        r_enable = 1'b1;
        init_i_t_a = init_i[AW-1:0];
        init_acc_t_a = init_acc;
        @(negedge clk);
        r_enable = 1'b0;
        lat = 0;
        while (!w_enable && lat < 1100) begin
            @(negedge clk);
            lat++;
        end
        seen = w_enable;
        got = result;
        @(negedge clk);
        total_cnt++;
        if (!seen || w_enable !== 1'b0)
            $display("FAIL pulse_width: seen=%0d w_enable_next=%b required seen=1 next=0", seen, w_enable);
        else pass_cnt++;
    endtask

    task automatic check_run(input string name, input int init_i, input longint init_acc, input int max_lat);
        longint got, exp;
        int lat;
        bit seen;
        exp = model_dot(init_i, init_acc);
        run_engine(init_i, init_acc, got, lat, seen);
        total_cnt++;
        if (got !== exp) $display("FAIL %s_result: got %0d required %0d", name, got, exp);
        else pass_cnt++;
        total_cnt++;
        if (!seen || lat > max_lat) $display("FAIL %s_latency: got %0d cycles required <= %0d", name, lat, max_lat);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r_enable = 1'b0;
        controlArr = 1'b1;
        init_i_t_a = '0;
        init_acc_t_a = '0;
        controlArrWEnable_a = 1'b0;
        controlArrWEnable_b = 1'b0;
        controlArrAddr_a = '0;
        controlArrAddr_b = '0;
        controlArrWData_a = '0;
        controlArrWData_b = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (w_enable !== 1'b0 || result !== '0)
            $display("FAIL reset_out: w_enable=%b result=%0h required 0/0", w_enable, result);
        else pass_cnt++;
        total_cnt++;
        if (controlArrRData_a !== '0 || controlArrRData_b !== '0)
            $display("FAIL reset_rdata: a=%0h b=%0h required 0", controlArrRData_a, controlArrRData_b);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_readback();
        int addrs [6];
        logic [2*DW-1:0] e;
        for (int k = 0; k < 6; k++) begin
            addrs[k] = int'($urandom_range(0, 1023));
            write_ab(addrs[k], rand_elem(), rand_elem());
        end
        // Read back each address; the last one was written on the edge just before, so it checks write-then-read.
        for (int k = 5; k >= 0; k--) begin
            @(negedge clk);
            controlArrWEnable_a = 1'b0;
            controlArrWEnable_b = 1'b0;
            controlArrAddr_a = addrs[k][AW-1:0];
            controlArrAddr_b = addrs[k][AW-1:0];
            exp_q.push_back({model_a[addrs[k]][DW-1:0], model_b[addrs[k]][DW-1:0]});
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++;
            if ({controlArrRData_a, controlArrRData_b} !== e)
                $display("FAIL readback[%0d]: got %0h/%0h required %0h/%0h", addrs[k],
                         controlArrRData_a, controlArrRData_b, e[2*DW-1:DW], e[DW-1:0]);
            else pass_cnt++;
        end
        // While the engine owns the arrays, host writes are ignored and read data is zero.
        @(negedge clk);
        controlArr = 1'b0;
        controlArrWEnable_a = 1'b1;
        controlArrWEnable_b = 1'b1;
        controlArrAddr_a = addrs[0][AW-1:0];
        controlArrAddr_b = addrs[0][AW-1:0];
        controlArrWData_a = ~model_a[addrs[0]][DW-1:0];
        controlArrWData_b = ~model_b[addrs[0]][DW-1:0];
        @(negedge clk);
        controlArrWEnable_a = 1'b0;
        controlArrWEnable_b = 1'b0;
        total_cnt++;
        if (controlArrRData_a !== '0 || controlArrRData_b !== '0)
            $display("FAIL rdata_engine_owned: a=%0h b=%0h required 0", controlArrRData_a, controlArrRData_b);
        else pass_cnt++;
        controlArr = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (controlArrRData_a !== model_a[addrs[0]][DW-1:0] || controlArrRData_b !== model_b[addrs[0]][DW-1:0])
            $display("FAIL write_ignored: got %0h/%0h required %0h/%0h", controlArrRData_a, controlArrRData_b,
                     model_a[addrs[0]][DW-1:0], model_b[addrs[0]][DW-1:0]);
        else pass_cnt++;
    endtask

    task automatic test_ramp();
        longint got;
        int lat;
        bit seen;
        for (int i = 0; i < 1024; i++) begin
            model_a[i] = (i < N) ? i - 500 : 0;
            model_b[i] = (i < N) ? 2 : 0;
        end
        load_all();
        run_engine(0, 0, got, lat, seen);
        total_cnt++;
        if (got !== -64'sd1000) $display("FAIL ramp_result: got %0d required -1000", got);
        else pass_cnt++;
    endtask

    task automatic test_min_operands();
        for (int i = 0; i < 1024; i++) begin
            model_a[i] = -67108864;
            model_b[i] = -67108864;
        end
        load_all();
        total_cnt++;
        if (model_dot(0, 0) !== (longint'(1000) << 52))
            $display("FAIL min_model: got %0d required %0d", model_dot(0, 0), longint'(1000) << 52);
        else pass_cnt++;
        check_run("min_operands", 0, 0, N + 8);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1024; i++) begin
            model_a[i] = rand_elem();
            model_b[i] = rand_elem();
        end
        load_all();
        check_run("random", 0, 0, N + 8);
        check_run("random_offset", int'($urandom_range(1, 900)), {$urandom, $urandom}, N + 8);
    endtask

    task automatic test_tail();
        write_ab(998, 3, 4);
        write_ab(999, -1, 7);
        host_idle();
        check_run("tail", 998, 5, 2 + 8);
        total_cnt++;
        if (model_dot(998, 5) !== 64'sd10) $display("FAIL tail_model: got %0d required 10", model_dot(998, 5));
        else pass_cnt++;
    endtask

    task automatic test_past_end();
        check_run("past_end", 1000, -9, 8);
    endtask

    task automatic test_busy_ignore();
        longint exp;
        int lat;
        int extra;
        exp = model_dot(0, 77);
        @(negedge clk);
        controlArr = 1'b0;
        r_enable = 1'b1;
        init_i_t_a = '0;
        init_acc_t_a = 64'd77;
        @(negedge clk);
        r_enable = 1'b0;
        repeat (10) @(negedge clk);
        r_enable = 1'b1;
        init_i_t_a = 10'd990;
        init_acc_t_a = 64'd12345;
        @(negedge clk);
        r_enable = 1'b0;
        lat = 0;
        while (!w_enable && lat < 1100) begin
            @(negedge clk);
            lat++;
        end
        total_cnt++;
        if (!w_enable || result !== exp) $display("FAIL busy_ignore: got %0d required %0d", result, exp);
        else pass_cnt++;
        // A start while the host owns the arrays must not launch a run.
        @(negedge clk);
        controlArr = 1'b1;
        r_enable = 1'b1;
        init_i_t_a = 10'd1000;
        init_acc_t_a = 64'd1;
        @(negedge clk);
        r_enable = 1'b0;
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (w_enable) extra++;
        end
        total_cnt++;
        if (extra != 0 || result !== exp)
            $display("FAIL host_start_ignored: pulses=%0d result=%0d required 0/%0d", extra, result, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        int pulses;
        longint acc0;
        acc0 = {$urandom, $urandom};
        @(negedge clk);
        controlArr = 1'b0;
        r_enable = 1'b1;
        init_i_t_a = 10'd100;
        init_acc_t_a = acc0;
        @(negedge clk);
        r_enable = 1'b0;
        pulses = 0;
        repeat (300) begin
            @(negedge clk);
            if (w_enable) pulses++;
        end
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (w_enable !== 1'b0 || result !== '0)
            $display("FAIL midrun_reset_out: w_enable=%b result=%0h required 0/0", w_enable, result);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (w_enable) pulses++;
        end
        total_cnt++;
        if (pulses != 0) $display("FAIL midrun_no_pulse: got %0d pulses required 0", pulses);
        else pass_cnt++;
        check_run("restart", 100, acc0, (N - 100) + 8);
    endtask

    initial begin
        test_reset();
        test_readback();
        test_ramp();
        test_min_operands();
        test_random();
        test_tail();
        test_past_end();
        test_busy_ignore();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
